haraka_add_round_key: RTL and testbench
=======================================

Name: haraka_add_round_key

Overview:
- Stage directly downstream of MixColumns in the Haraka-S AES-round datapath.
- Accepts each 128-bit MixColumns result on a valid/ready stream and XORs it with the next Haraka round constant.
- Round constants come from an internal round-constant index counter.
- Output is fully registered, with a 2-entry skid buffer so in_ready is registered and back-pressure never combinationally crosses the stage.

Parameters:
- NUM_RC, 40, number of round constants cycled through (5 rounds x 2 AES rounds x 4 lanes for Haraka-512).
- RC_W, 6, width of the round-constant index; must satisfy 2**RC_W >= NUM_RC.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rc_clear  input  1  synchronous pulse: round-constant index returns to 0 (start of a new permutation).
- in_valid  input  1  upstream (MixColumns) data valid.
- in_ready  output  1  stage can accept a beat; registered.
- in_data  input  128  MixColumns output state, same byte order as MixColumns.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts a beat.
- out_data  output  128  in_data XOR HARAKA_RC[idx], where idx is the index at acceptance.
- out_rc_idx  output  RC_W  index used for the beat on out_data.
- out_last  output  1  beat used index NUM_RC-1 (last constant of the permutation).

Behaviour:
- Reset values (asynchronous on rst_n low): out_valid=0, in_ready=1, out_data=0, out_rc_idx=0, out_last=0, rc index=0, skid entry empty.
- Accept on in_valid & in_ready. Emit on out_valid & out_ready.
- Storage: main output register plus one skid register.
- States:
  - EMPTY (in_ready=1, out_valid=0).
  - ONE (main full; in_ready=1, out_valid=1).
  - FULL (main+skid full; in_ready=0, out_valid=1).
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept without emit -> FULL.
  - ONE + emit without accept -> EMPTY.
  - ONE + accept and emit -> ONE; main reloads with the new beat.
  - FULL + emit -> ONE; skid moves to main.
  - FULL never accepts.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 beat/cycle while out_ready=1.
- XOR is computed at acceptance. Index and last flag are stored alongside data in both entries.
- Ordering is strictly FIFO; no beat may be dropped or duplicated.
- RC index:
  - Increments by 1 on each accept.
  - Wraps from NUM_RC-1 to 0.
  - rc_clear has priority over the increment: if rc_clear and accept occur in the same cycle, the accepted beat uses the current index and the next index is 0.
- rc_clear does not flush buffered beats.
- Mid-operation reset: all buffered beats are discarded; state returns to reset values on the next cycle regardless of handshakes.
- out_data, out_rc_idx and out_last hold stable while out_valid=1 and out_ready=0.
- Input data is ignored when in_valid=0 or in_ready=0.
- No combinational path from out_ready to in_ready or from in_data to out_data.

Decomposition:
- Shared package haraka_pkg holds:
  - localparam HARAKA_NUM_RC=40.
  - The HARAKA_RC[0:39] 128-bit constant array, in the same byte order as the MixColumns data.
  - typedef state128_t (logic [127:0]).
  - typedef rc_idx_t.
- One sub-module, haraka_skid_buf: a 2-entry valid/ready register slice, parameterised on payload width (128+RC_W+1).
- Top level holds the index counter and XOR, and instantiates haraka_skid_buf.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0; first accepted beat after release has out_rc_idx=0.
- Single beat, out_ready=1: in_data=128'hc2384d1874b136ad378e6bfa95432594 -> one cycle later out_data=in_data^HARAKA_RC[0], out_rc_idx=0, out_last=0. Then in_data=0 -> out_data==HARAKA_RC[1] exactly.
- Streaming wrap: 41 back-to-back beats of in_data=0, out_ready=1 -> out_data sequence HARAKA_RC[0..39],HARAKA_RC[0]; out_last=1 only on beat 40; no bubbles.
- Back-pressure: out_ready=0, send beats A=128'h1, B=128'h2 -> in_ready falls after B; A held stable. Raise out_ready -> A then B emitted in order with idx 0,1; in_ready returns 1 one cycle after FULL drains.
- rc_clear: after 5 accepts, assert rc_clear together with the 6th accept -> 6th beat uses idx 5, 7th beat uses idx 0; buffered beats unaffected.
- Reset mid-stream while FULL: rst_n low for 1 cycle -> out_valid=0 immediately (asynchronous); after release idx=0 and no stale beat is emitted.

Source files
------------

// File: rtl/haraka_pkg.sv
// Shared Haraka types and round constants.
// Each constant is the 128-bit lane value with word 3 in the MSBs, matching the MixColumns byte order.
package haraka_pkg;

  localparam int unsigned HARAKA_NUM_RC = 40;
  localparam int unsigned HARAKA_RC_W   = 6;

  typedef logic [127:0]           state128_t;
  typedef logic [HARAKA_RC_W-1:0] rc_idx_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

  localparam state128_t HARAKA_RC [0:HARAKA_NUM_RC-1] = '{
    128'h0684704c_e620c00a_b2c5fef0_75817b9d,
    128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
    128'h3402de2d_53f28498_cf029d60_9f029114,
    128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
    128'hcbcfb0cb_4872448b_79eecd1c_be397044,
    128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
    128'h67c28f43_5e2e7cd0_e2412761_da4fef1b,
    128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
    128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee,
    128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
    128'hb2cc0bb9_941723bf_69028b2e_8df69800,
    128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
    128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4,
    128'h1ea10344_f449a236_32d611ae_bb6a12ee,
    128'haf044988_4b050084_5f9600c9_9ca8eca6,
    128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
    128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173,
    128'h6260700d_6186b017_37f2efd9_10307d6b,
    128'h5aca45c2_21300443_81c29153_f6fc9ac6,
    128'h9223973c_226b68bb_2caf92e8_36d1943a,
    128'hd3bf9238_225886eb_6cbab958_e51071b4,
    128'hdb863ce5_aef0c677_933dfddd_24e1128d,
    128'hbb606268_ffeba09c_83e48de3_cb2212b1,
    128'h734bd3dc_e2e4d19c_2db91a4e_c72bf77d,
    128'h43bb47c3_61301b43_4b1415c4_2cb3924e,
    128'hdba775a8_e707eff6_03b231dd_16eb6899,
    128'h6df3614b_3c755977_8e5e2302_7eca472c,
    128'hcda75a17_d6de7d77_6d1be5b9_b88617f9,
    128'hec6b43f0_6ba8e9aa_9d6c069d_a946ee5d,
    128'hcb1e6950_f957332b_a2531159_3bf327c1,
    128'h2cee0c75_00da619c_e4ed0353_600ed0d9,
    128'hf0b1a5a1_96e90cab_80bbbabc_63a4a350,
    128'hae3db102_5e962988_ab0dde30_938dca39,
    128'h17bb8f38_d554a40b_8814f3a8_2e75b442,
    128'h34bb8a5b_5f427fd7_aeb6b779_360a16f6,
    128'h26f65241_cbe55438_43ce5918_ffbaafde,
    128'h4ce99a54_b9f3026a_a2ca9cf7_839ec978,
    128'hae51a51a_1bdff7be_40c06e28_22901235,
    128'ha0c1613c_ba7ed22b_c173bc0f_48a659cf,
    128'h756acc03_02288288_4ad6bdfd_e9c59da1
  };

  // Out-of-range indices map to zero so a wider index counter never reads past the table.
  function automatic state128_t haraka_rc(input int unsigned idx);
    state128_t rc;
    rc = '0;
    for (int unsigned i = 0; i < HARAKA_NUM_RC; i++) begin
      if (idx == i) rc = HARAKA_RC[rc_idx_t'(i)];
    end
    return rc;
  endfunction

endpackage

// File: rtl/haraka_skid_buf.sv
// Two-entry valid/ready register slice: registered in_ready, registered out_valid and out_data.
module haraka_skid_buf
  import haraka_pkg::*;
#(
  parameter int unsigned W = 135
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         emit;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      out_data  <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state_q   <= StOne;
          end
        end
        StOne: begin
          if (accept && !emit) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state_q  <= StFull;
          end else if (!accept && emit) begin
            out_valid <= 1'b0;
            state_q   <= StEmpty;
          end else if (accept && emit) begin
            out_data <= in_data;
          end
        end
        StFull: begin
          // in_ready is low here, so only the drain of the main entry can happen.
          if (emit) begin
            out_data <= skid_q;
            in_ready <= 1'b1;
            state_q  <= StOne;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= StEmpty;
        end
      endcase
    end
  end

endmodule

// File: rtl/haraka_add_round_key.sv
// Haraka AddRoundKey stage: XORs each MixColumns beat with the next round constant.
module haraka_add_round_key
  import haraka_pkg::*;
#(
  parameter int unsigned NUM_RC = 40,
  parameter int unsigned RC_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rc_clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic [RC_W-1:0] out_rc_idx,
  output logic            out_last
);

  localparam int unsigned PayloadW = 128 + RC_W + 1;

  logic [RC_W-1:0]     rc_idx_q;
  logic [RC_W-1:0]     rc_idx_d;
  logic                accept;
  logic                last_idx;
  state128_t           keyed;
  logic [PayloadW-1:0] in_payload;
  logic [PayloadW-1:0] out_payload;

  assign accept     = in_valid & in_ready;
  assign last_idx   = (rc_idx_q == RC_W'(NUM_RC - 1));
  assign keyed      = in_data ^ haraka_rc(32'(rc_idx_q));
  assign in_payload = {keyed, rc_idx_q, last_idx};

  // A clear wins over the increment; the beat accepted alongside it still uses the current index.
  always_comb begin
    rc_idx_d = rc_idx_q;
    if (rc_clear) begin
      rc_idx_d = '0;
    end else if (accept) begin
      rc_idx_d = last_idx ? '0 : rc_idx_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_idx_q <= '0;
    end else begin
      rc_idx_q <= rc_idx_d;
    end
  end

  haraka_skid_buf #(
    .W (PayloadW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_data   = out_payload[PayloadW-1 -: 128];
  assign out_rc_idx = out_payload[RC_W:1];
  assign out_last   = out_payload[0];

endmodule

// File: tb/tb_haraka_add_round_key.sv
// Self-checking bench for haraka_add_round_key: directed vectors plus a queue-based reference model.
module tb_haraka_add_round_key;

  localparam int NRC = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rc_clear;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [5:0]   out_rc_idx;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  haraka_add_round_key #(
    .NUM_RC (40),
    .RC_W   (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rc_clear   (rc_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rc_idx (out_rc_idx),
    .out_last   (out_last)
  );

  // Published Haraka round constants, independent copy for the reference model.
  logic [127:0] ref_rc [NRC] = '{
    128'h0684704ce620c00ab2c5fef075817b9d, 128'h8b66b4e188f3a06b640f6ba42f08f717,
    128'h3402de2d53f28498cf029d609f029114, 128'h0ed6eae62e7b4f08bbf3bcaffd5b4f79,
    128'hcbcfb0cb4872448b79eecd1cbe397044, 128'h7eeacdee6e9032b78d5335ed2b8a057b,
    128'h67c28f435e2e7cd0e2412761da4fef1b, 128'h2924d9b0afcacc07675ffde21fc70b3b,
    128'hab4d63f1e6867fe9ecdb8fcab9d465ee, 128'h1c30bf84d4b7cd645b2a404fad037e33,
    128'hb2cc0bb9941723bf69028b2e8df69800, 128'hfa0478a6de6f55724aaa9ec85c9d2d8a,
    128'hdfb49f2b6b772a120efa4f2e29129fd4, 128'h1ea10344f449a23632d611aebb6a12ee,
    128'haf0449884b0500845f9600c99ca8eca6, 128'h21025ed89d199c4f78a2c7e327e593ec,
    128'hbf3aaaf8a759c9b7b9282ecd82d40173, 128'h6260700d6186b01737f2efd910307d6b,
    128'h5aca45c22130044381c29153f6fc9ac6, 128'h9223973c226b68bb2caf92e836d1943a,
    128'hd3bf9238225886eb6cbab958e51071b4, 128'hdb863ce5aef0c677933dfddd24e1128d,
    128'hbb606268ffeba09c83e48de3cb2212b1, 128'h734bd3dce2e4d19c2db91a4ec72bf77d,
    128'h43bb47c361301b434b1415c42cb3924e, 128'hdba775a8e707eff603b231dd16eb6899,
    128'h6df3614b3c7559778e5e23027eca472c, 128'hcda75a17d6de7d776d1be5b9b88617f9,
    128'hec6b43f06ba8e9aa9d6c069da946ee5d, 128'hcb1e6950f957332ba25311593bf327c1,
    128'h2cee0c7500da619ce4ed0353600ed0d9, 128'hf0b1a5a196e90cab80bbbabc63a4a350,
    128'hae3db1025e962988ab0dde30938dca39, 128'h17bb8f38d554a40b8814f3a82e75b442,
    128'h34bb8a5b5f427fd7aeb6b779360a16f6, 128'h26f65241cbe5543843ce5918ffbaafde,
    128'h4ce99a54b9f3026aa2ca9cf7839ec978, 128'hae51a51a1bdff7be40c06e2822901235,
    128'ha0c1613cba7ed22bc173bc0f48a659cf, 128'h756acc03022882884ad6bdfde9c59da1
  };

  typedef struct {
    logic [127:0] data;
    logic [5:0]   idx;
    logic         last;
  } beat_t;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    logic [5:0]   idx;
    logic         last;
  } vec_t;

  beat_t exp_q[$];
  int    m_idx = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: every accepted beat is queued with its constant; every emitted beat must
  // match the queue head; a stalled output must not change.
  initial begin : monitor
    logic         stall_prev;
    logic [127:0] prev_data;
    logic [5:0]   prev_idx;
    logic         prev_last;
    beat_t        e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_idx = 0;
        stall_prev = 1'b0;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_rc_idx", 128'(out_rc_idx), 128'd0);
      end else begin
        if (stall_prev) begin
          check("stall_data", out_data, prev_data);
          check("stall_idx", 128'(out_rc_idx), 128'(prev_idx));
          check("stall_last", 128'(out_last), 128'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_beat", 128'(out_valid), 128'd0);
          end else begin
            e = exp_q.pop_front();
            check("model_data", out_data, e.data);
            check("model_idx", 128'(out_rc_idx), 128'(e.idx));
            check("model_last", 128'(out_last), 128'(e.last));
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back('{data: in_data ^ ref_rc[6'(m_idx)], idx: 6'(m_idx),
                            last: (m_idx == NRC - 1)});
        end
        if (rc_clear) m_idx = 0;
        else if (in_valid && in_ready) m_idx = (m_idx + 1) % NRC;
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_rc_idx;
        prev_last  = out_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic clr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    rc_clear = clr;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    rc_clear = 1'b0;
  endtask

  task automatic clear_idx();
    rc_clear = 1'b1;
    tick();
    rc_clear = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    vec_t         vecs[4];
    logic [127:0] r;
    logic [127:0] a_exp;

    r = rand128();
    vecs[0] = '{128'hc2384d1874b136ad378e6bfa95432594,
                128'hc2384d1874b136ad378e6bfa95432594 ^ ref_rc[0], 6'd0, 1'b0};
    vecs[1] = '{128'd0, ref_rc[1], 6'd1, 1'b0};
    vecs[2] = '{r, r ^ ref_rc[2], 6'd2, 1'b0};
    r = rand128();
    vecs[3] = '{r, r ^ ref_rc[3], 6'd3, 1'b0};

    // Reset held with in_valid high.
    rst_n     = 1'b0;
    rc_clear  = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand128();
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("reset_out_valid", 128'(out_valid), 128'd0);
      check("reset_in_ready", 128'(in_ready), 128'd1);
      check("reset_out_data", out_data, 128'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Table-driven single beats.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].din, 1'b0);
      check("vec_valid", 128'(out_valid), 128'd1);
      check("vec_data", out_data, vecs[i].dout);
      check("vec_idx", 128'(out_rc_idx), 128'(vecs[i].idx));
      check("vec_last", 128'(out_last), 128'(vecs[i].last));
      tick();
      check("vec_drained", 128'(out_valid), 128'd0);
    end

    // 41 back-to-back zero beats: constants in order, wrap, no bubbles.
    clear_idx();
    in_valid = 1'b1;
    in_data  = 128'd0;
    for (int k = 0; k < 41; k++) begin
      tick();
      check("stream_valid", 128'(out_valid), 128'd1);
      check("stream_ready", 128'(in_ready), 128'd1);
      check("stream_data", out_data, ref_rc[6'(k % NRC)]);
      check("stream_idx", 128'(out_rc_idx), 128'(k % NRC));
      check("stream_last", 128'(out_last), 128'(k == NRC - 1));
    end
    in_valid = 1'b0;
    tick();

    // Back-pressure: fill both entries, ignore input while full, drain in order.
    clear_idx();
    out_ready = 1'b0;
    a_exp = 128'h1 ^ ref_rc[0];
    send(128'h1, 1'b0);
    check("bp_one_valid", 128'(out_valid), 128'd1);
    check("bp_one_ready", 128'(in_ready), 128'd1);
    send(128'h2, 1'b0);
    check("bp_full_ready", 128'(in_ready), 128'd0);
    check("bp_full_data", out_data, a_exp);
    in_valid = 1'b1;
    in_data  = rand128();
    tick();
    tick();
    in_valid = 1'b0;
    check("bp_hold_data", out_data, a_exp);
    check("bp_hold_idx", 128'(out_rc_idx), 128'd0);
    check("bp_hold_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    tick();
    check("bp_b_data", out_data, 128'h2 ^ ref_rc[1]);
    check("bp_b_idx", 128'(out_rc_idx), 128'd1);
    check("bp_b_ready", 128'(in_ready), 128'd1);
    tick();
    check("bp_empty", 128'(out_valid), 128'd0);

    // rc_clear together with the sixth accept.
    clear_idx();
    for (int j = 0; j < 5; j++) send(rand128(), 1'b0);
    send(rand128(), 1'b1);
    check("clr_sixth_idx", 128'(out_rc_idx), 128'd5);
    send(rand128(), 1'b0);
    check("clr_seventh_idx", 128'(out_rc_idx), 128'd0);
    tick();

    // Randomized traffic against the model, including buffered beats across rc_clear.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand128();
      out_ready = ($urandom_range(0, 2) != 0);
      rc_clear  = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid  = 1'b0;
    rc_clear  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("drain_out_valid", 128'(out_valid), 128'd0);
    check("drain_model_empty", 128'(exp_q.size()), 128'd0);

    // Asynchronous reset while full; nothing stale may appear afterwards.
    clear_idx();
    out_ready = 1'b0;
    send(rand128(), 1'b0);
    send(rand128(), 1'b0);
    check("mid_full_ready", 128'(in_ready), 128'd0);
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", 128'(out_valid), 128'd0);
    check("mid_async_ready", 128'(in_ready), 128'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("mid_no_stale", 128'(out_valid), 128'd0);
    end
    send(128'd0, 1'b0);
    check("mid_first_data", out_data, ref_rc[0]);
    check("mid_first_idx", 128'(out_rc_idx), 128'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
